// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C register target: FSM state encoding,
// ACK/NACK bus levels, synchronizer depth and the majority-vote helper.
package i2c_slave_pkg;

    localparam int SYNC_DEPTH = 2;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } i2c_slv_state_t;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
    endfunction

endpackage

// File: rtl/i2c_slave_in_filter.sv
// One bus line: 2-flop synchronizer, optional 3-sample majority filter
// (I2C_SLAVE_GLITCH_FILTER_EN) and rise/fall detection on the cleaned level.
module i2c_slave_in_filter
    import i2c_slave_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  filt;
    logic                  prev_q;

    // Idle I2C lines are pulled high, so every stage resets to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '1;
        end else begin
            // NOTE: non-blocking assignment lets each flop sample the previous stage's old value, forming a real shift chain.
            sync_q <= {sync_q[SYNC_DEPTH-2:0], line};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] win_q;
    logic       maj_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            win_q <= '1;
            maj_q <= 1'b1;
        end else begin
            win_q <= {win_q[1:0], sync_q[SYNC_DEPTH-1]};
            maj_q <= majority3(win_q);
        end
    end

    assign filt = maj_q;
`else
    assign filt = sync_q[SYNC_DEPTH-1];
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= filt;
        end
    end

    assign level = filt;
    assign rise  = filt & ~prev_q;
    assign fall  = ~filt & prev_q;

endmodule

// File: rtl/i2c_reg_slave_sv.sv
// I2C target with a byte-wide register file, auto-incrementing pointer and a host read port.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a majority glitch filter on scl/sda.
module i2c_reg_slave_sv
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0]  chip_addr = 7'h18,
    parameter int unsigned depth     = 256
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] host_addr,
    output logic [7:0] host_rdata,
    output logic       wr_stb,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int         AW       = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [7:0] PTR_MASK = 8'(depth - 1);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_slave_in_filter u_scl_filter (
        .clk    (clk),
        .resetn (resetn),
        .line   (scl),
        .level  (scl_lvl),
        .rise   (scl_rise),
        .fall   (scl_fall)
    );

    i2c_slave_in_filter u_sda_filter (
        .clk    (clk),
        .resetn (resetn),
        .line   (sda),
        .level  (sda_lvl),
        .rise   (sda_rise),
        .fall   (sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    i2c_slv_state_t state_q, state_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic [7:0]     ptr_q, ptr_d;
    logic           rw_q, rw_d;
    logic           sda_low_q, sda_low_d;
    logic           busy_q, busy_d;
    logic           wr_stb_q, wr_stb_d;
    logic [7:0]     wr_addr_q, wr_addr_d;
    logic [7:0]     wr_data_q, wr_data_d;

    logic [7:0] mem [depth];
    logic [7:0] rd_byte;
    logic [7:0] rx_byte;
    logic       byte_done;

    assign rd_byte   = mem[ptr_q[AW-1:0]];
    assign rx_byte   = {shreg_q[6:0], sda_lvl};
    assign byte_done = scl_rise && (bit_cnt_q == 4'd7);

    always_comb begin
        // NOTE: every next-state variable gets a hold/default value first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        sda_low_d = sda_low_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
        end else begin
            if ((state_q inside {ST_ADDR, ST_PTR, ST_WDATA}) && scl_rise) begin
                shreg_d   = rx_byte;
                bit_cnt_d = bit_cnt_q + 4'd1;
            end

            unique case (state_q)
                ST_IDLE: ;

                ST_ADDR: begin
                    if (byte_done) begin
                        bit_cnt_d = '0;
                        if (rx_byte[7:1] == chip_addr) begin
                            state_d = ST_ADDR_ACK;
                            rw_d    = rx_byte[0];
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end

                ST_PTR: begin
                    if (byte_done) begin
                        bit_cnt_d = '0;
                        ptr_d     = rx_byte & PTR_MASK;
                        state_d   = ST_PTR_ACK;
                    end
                end

                ST_WDATA: begin
                    if (byte_done) begin
                        bit_cnt_d = '0;
                        wr_stb_d  = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = rx_byte;
                        ptr_d     = (ptr_q + 8'd1) & PTR_MASK;
                        state_d   = ST_WDATA_ACK;
                    end
                end

                // First scl fall after the byte asserts ACK, the next one releases it.
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_low_q) begin
                            sda_low_d = ~I2C_ACK;
                        end else begin
                            sda_low_d = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                state_d   = ST_RDATA;
                                shreg_d   = rd_byte;
                                sda_low_d = ~rd_byte[7];
                            end else if (state_q == ST_ADDR_ACK) begin
                                state_d = ST_PTR;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end

                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d   = ST_RDATA_ACK;
                            sda_low_d = 1'b0;
                        end else begin
                            shreg_d   = {shreg_q[6:0], 1'b0};
                            sda_low_d = ~shreg_q[6];
                        end
                    end
                end

                // bit_cnt = 9 marks "master ACKed, next byte goes out on the coming fall".
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == I2C_NACK) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            ptr_d     = (ptr_q + 8'd1) & PTR_MASK;
                            bit_cnt_d = 4'd9;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        state_d   = ST_RDATA;
                        bit_cnt_d = '0;
                        shreg_d   = rd_byte;
                        sda_low_d = ~rd_byte[7];
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            sda_low_q <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            sda_low_q <= sda_low_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Writing from the strobe registers keeps host_rdata at the old value during the wr_stb cycle.
    // NOTE: the register file is deliberately not reset so it maps onto plain RAM; contents are valid only once written.
    always_ff @(posedge clk) begin
        if (wr_stb_q) begin
            mem[wr_addr_q[AW-1:0]] <= wr_data_q;
        end
    end

    assign host_rdata = mem[host_addr[AW-1:0]];
    assign sda        = sda_low_q ? 1'b0 : 1'bz;
    assign wr_stb     = wr_stb_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_reg_slave_sv.sv
// Bench for i2c_reg_slave_sv: bus-level master, register-file reference model,
// and a scoreboard whose monitors check strobed writes and returned read bytes.
module tb_i2c_reg_slave_sv;

    localparam int         Q    = 8;
    localparam logic [6:0] CHIP = 7'h18;

    logic       clk       = 1'b0;
    logic       resetn    = 1'b0;
    logic       scl       = 1'b1;
    logic       m_sda_low = 1'b0;
    logic [7:0] host_addr = 8'h00;
    logic [7:0] host_rdata;
    logic       wr_stb;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    wire        sda;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_reg_slave_sv #(
        .chip_addr (CHIP),
        .depth     (256)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .scl        (scl),
        .sda        (sda),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .wr_stb     (wr_stb),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: register file contents, which bytes are known, and the pointer.
    logic [7:0] ref_mem   [256];
    bit         ref_known [256];
    logic [7:0] ref_ptr = 8'h00;
    logic [7:0] wbuf [8];

    typedef struct packed {logic [7:0] addr; logic [7:0] data;} wr_t;
    typedef struct packed {logic known; logic [7:0] data;} rd_t;
    wr_t        exp_wr_q[$];
    rd_t        exp_rd_q[$];
    logic [7:0] got_rd_q[$];
    wr_t        mon_wr;
    rd_t        mon_rd;
    logic [7:0] mon_got;
    int         dut_low_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each wr_stb pops one expected write; each received byte pops one expected read.
    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wr_stb_unexpected: got addr 0x%02h data 0x%02h, expected no write", wr_addr, wr_data);
            end else begin
                mon_wr = exp_wr_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(mon_wr.addr));
                check("wr_data", 32'(wr_data), 32'(mon_wr.data));
            end
        end
        if (got_rd_q.size() != 0) begin
            mon_got = got_rd_q.pop_front();
            if (exp_rd_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_unexpected: got 0x%02h, expected no read byte", mon_got);
            end else begin
                mon_rd = exp_rd_q.pop_front();
                if (mon_rd.known) check("rd_data", 32'(mon_got), 32'(mon_rd.data));
            end
        end
    end

    always @(negedge clk) begin
        if (sda === 1'b0 && !m_sda_low) dut_low_cnt++;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0; tick(Q);
        scl = 1'b1;       tick(Q);
        m_sda_low = 1'b1; tick(Q);
        scl = 1'b0;       tick(Q);
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; tick(Q);
        scl = 1'b1;       tick(Q);
        m_sda_low = 1'b0; tick(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b; tick(Q);
        scl = 1'b1;     tick(2 * Q);
        scl = 1'b0;     tick(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0; tick(Q);
        scl = 1'b1;       tick(Q);
        b = sda;          tick(Q);
        scl = 1'b0;       tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic last);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        got_rd_q.push_back(d);
        write_bit(last);
    endtask

    // Write transaction: address, pointer, then n bytes from wbuf.
    task automatic do_write(input logic [7:0] ptr, input int n);
        logic ack;
        bus_start();
        write_byte({CHIP, 1'b0}, ack);
        check("ack_addr_w", 32'(ack), 32'd0);
        check("busy_addressed", 32'(busy), 32'd1);
        write_byte(ptr, ack);
        check("ack_ptr", 32'(ack), 32'd0);
        ref_ptr = ptr;
        for (int k = 0; k < n; k++) begin
            exp_wr_q.push_back('{addr: ref_ptr, data: wbuf[k]});
            ref_mem[ref_ptr]   = wbuf[k];
            ref_known[ref_ptr] = 1'b1;
            ref_ptr            = ref_ptr + 8'd1;
            write_byte(wbuf[k], ack);
            check("ack_wdata", 32'(ack), 32'd0);
        end
        bus_stop();
        check("busy_after_stop", 32'(busy), 32'd0);
    endtask

    // Read transaction, optionally setting the pointer first via a repeated START.
    task automatic do_read(input bit set_ptr, input logic [7:0] ptr, input int n);
        logic       ack;
        logic [7:0] d;
        bus_start();
        if (set_ptr) begin
            write_byte({CHIP, 1'b0}, ack);
            check("ack_addr_w", 32'(ack), 32'd0);
            write_byte(ptr, ack);
            check("ack_ptr", 32'(ack), 32'd0);
            ref_ptr = ptr;
            bus_start();
        end
        write_byte({CHIP, 1'b1}, ack);
        check("ack_addr_r", 32'(ack), 32'd0);
        for (int k = 0; k < n; k++) begin
            exp_rd_q.push_back('{known: ref_known[ref_ptr], data: ref_mem[ref_ptr]});
            read_byte(d, (k == n - 1));
            if (k != n - 1) ref_ptr = ref_ptr + 8'd1;
        end
        check("busy_after_nack", 32'(busy), 32'd0);
        bus_stop();
    endtask

    task automatic host_read(input logic [7:0] a);
        host_addr = a;
        @(negedge clk);
        if (ref_known[a]) check("host_rdata", 32'(host_rdata), 32'(ref_mem[a]));
    endtask

    initial begin
        logic       ack;
        int         kind;
        int         n;
        int         cnt0;
        logic [7:0] p;
        logic [7:0] last_base;
        logic [7:0] d;

        last_base = 8'h10;
        tick(3);
        @(negedge clk);
        check("reset_sda_released", 32'(sda), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_wr_stb", 32'(wr_stb), 32'd0);
        check("reset_wr_addr", 32'(wr_addr), 32'd0);
        check("reset_wr_data", 32'(wr_data), 32'd0);
        resetn = 1'b1;
        tick(4);

        // Two-byte write at 0x10, then host-side readback.
        wbuf[0] = 8'hA5;
        wbuf[1] = 8'h5A;
        do_write(8'h10, 2);
        host_read(8'h11);
        host_read(8'h10);

        // Pointer write, repeated START, two-byte read.
        do_read(1'b1, 8'h10, 2);

        // Foreign address: no ACK, no drive, no busy, no write.
        cnt0 = dut_low_cnt;
        bus_start();
        write_byte(8'd50, ack);
        check("nack_foreign_addr", 32'(ack), 32'd1);
        check("busy_foreign", 32'(busy), 32'd0);
        write_byte(8'h33, ack);
        check("nack_foreign_data", 32'(ack), 32'd1);
        bus_stop();
        check("foreign_sda_never_low", 32'(dut_low_cnt), 32'(cnt0));

        // Pointer wrap 0xFF -> 0x00.
        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        do_write(8'hFF, 2);
        host_read(8'hFF);
        host_read(8'h00);

        // STOP after a partial data byte, then a normal transaction.
        bus_start();
        write_byte({CHIP, 1'b0}, ack);
        write_byte(8'h40, ack);
        ref_ptr = 8'h40;
        for (int i = 0; i < 4; i++) write_bit(1'(i & 1));
        bus_stop();
        check("busy_partial_stop", 32'(busy), 32'd0);
        wbuf[0] = 8'h77;
        do_write(8'h40, 1);
        host_read(8'h40);

        // Randomized mix of writes, pointer-set reads and reads at the retained pointer.
        for (int t = 0; t < 16; t++) begin
            kind = int'($urandom_range(0, 2));
            n    = int'($urandom_range(1, 3));
            if (kind == 0) begin
                p = 8'($urandom);
                for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
                do_write(p, n);
                last_base = p;
                host_read(p);
            end else if (kind == 1) begin
                p = ($urandom_range(0, 1) == 1) ? last_base : 8'($urandom);
                do_read(1'b1, p, n);
            end else begin
                do_read(1'b0, 8'h00, n);
            end
        end

        // Reset asserted while the target holds ACK low.
        bus_start();
        write_byte({CHIP, 1'b0}, ack);
        write_byte(8'h20, ack);
        ref_ptr = 8'h20;
        d = 8'h99;
        exp_wr_q.push_back('{addr: 8'h20, data: d});
        ref_mem[8'h20]   = d;
        ref_known[8'h20] = 1'b1;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        m_sda_low = 1'b0;
        @(negedge clk);
        check("ack_window_sda_low", 32'(sda), 32'd0);
        resetn = 1'b0;
        #1;
        check("reset_mid_sda_released", 32'(sda), 32'd1);
        check("reset_mid_busy", 32'(busy), 32'd0);
        check("reset_mid_wr_stb", 32'(wr_stb), 32'd0);
        check("reset_mid_wr_addr", 32'(wr_addr), 32'd0);
        check("reset_mid_wr_data", 32'(wr_data), 32'd0);
        scl = 1'b1;
        tick(Q);
        resetn = 1'b1;
        ref_ptr = 8'h00;
        tick(Q);
        do_read(1'b0, 8'h00, 2);

        tick(4);
        check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_reg_slave_sv.md
# i2c_reg_slave_sv

Synthesizable I2C target (slave) with an internal byte-wide register file: the responder side of `i2c_master_sv`, sharing its open-drain `scl`/`sda` bus. It samples the bus with the system clock, detects START/STOP, and matches a 7-bit chip address. It accepts a register-pointer byte followed by auto-incrementing writes, or serves auto-incrementing reads. It replaces the behavioural memory slave in system-level simulation and is the target used in FPGA loop-back builds.

## Interface
- `chip_addr`, default 24 (7'h18; bus address byte 48 = write, 49 = read): 7-bit target address.
- `depth`, default 256: register-file depth in bytes; must be a power of 2 and ≤ 256.
- `clk  in  1`: system clock; must be ≥ 16× the SCL frequency.
- `resetn  in  1`: asynchronous, active-low reset.
- `scl  in  1`: I2C clock; the block never drives it.
- `sda  inout  1`: I2C data, open-drain; the block drives only `1'b0` or `'z`.
- `host_addr  in  8`: host-side read address; bits above log2(depth) are ignored.
- `host_rdata  out  8`: combinational read of `mem[host_addr]`.
- `wr_stb  out  1`: one-cycle pulse for each byte written from the bus.
- `wr_addr  out  8`: address of the byte written; valid while `wr_stb` is high.
- `wr_data  out  8`: data of the byte written; valid while `wr_stb` is high.
- `busy  out  1`: high from an addressed START until STOP or a NACK release.

## Operation
- **Bus sampling.**
  - `scl` and `sda` each pass through a 2-flop synchronizer, then an optional filter (see Configuration).
  - Edges are detected on the filtered signals.
- **Condition detection.**
  - START: falling edge of sda while scl = 1.
  - STOP: rising edge of sda while scl = 1.
  - Both are recognised in every state. A START inside a frame is a repeated START and goes to ADDR.
- **Bit sampling.** Data bits are sampled on the scl rising edge, MSB first.
- **FSM states.** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- **IDLE** → ADDR on START.
- **ADDR**: after 8 bits, the target is selected when `byte[7:1] == chip_addr`.
  - Selected: → ADDR_ACK and latch R/W.
  - Not selected: → IDLE, with no ACK and sda released.
- **ADDR_ACK**: drive sda low for the 9th clock.
  - Then → PTR if R/W = 0, or → RDATA if R/W = 1.
  - RDATA loads `mem[ptr]` into the shift register.
- **PTR**: after 8 bits, `ptr <= byte`, → PTR_ACK (ACK), then → WDATA.
- **WDATA**: after 8 bits, write `mem[ptr] <= byte`.
  - Pulse `wr_stb` with `wr_addr = ptr` and `wr_data = byte`.
  - `ptr <= ptr + 1`, then → WDATA_ACK (ACK), then → WDATA.
- **RDATA**: shift out 8 bits, driving sda low for 0 bits and releasing it for 1 bits; then → RDATA_ACK, with sda released.
- **RDATA_ACK**: sample the master's ACK on the scl rise.
  - ACK (0): `ptr <= ptr + 1`, load the next byte, → RDATA.
  - NACK (1): → IDLE and clear `busy`.
- **Pointer arithmetic.** `ptr` is 8 bits and wraps modulo `depth`, so 255 + 1 = 0 at depth 256.
- **Pointer retention.** `ptr` is kept across transactions, so "write pointer, repeated START, read" works.
- **STOP in any state** → IDLE, sda released, `busy` = 0. A partial byte is discarded and no write occurs.

## Timing
- **Input latency:** an edge on the bus is seen 2 clk after it occurs, or 5 clk with the filter.
- **sda changes only after an scl fall** (synchronized), 1 clk after detection. This holds for ACK assertion, ACK release and read-bit update.
- **ACK window:** sda is held low from the scl fall after bit 8 until the scl fall after bit 9.
- **`wr_stb` timing:** high for exactly 1 clk, on the cycle after the 8th data bit is sampled. The memory update is visible on `host_rdata` on the following clk.
- **Reset values:**
  - sda = 'z
  - `busy` = 0
  - `wr_stb` = 0
  - `wr_addr` = 0
  - `wr_data` = 0
  - `ptr` = 0
  - FSM = IDLE
  - memory contents are not reset
- **Reset asserted mid-transfer:** sda is released immediately (asynchronously).
- **Simultaneous `wr_stb` and host read of the same address:** `host_rdata` shows the old value in that cycle.

## Configuration
- `I2C_SLAVE_GLITCH_FILTER_EN` defined:
  - scl and sda each pass through a 3-sample majority filter after the synchronizer.
  - Pulses of 1 clk are rejected.
  - Input latency becomes 5 clk.
- Not defined: no filter, and input latency is 2 clk.

## Structure
- Package `i2c_slave_pkg` holds:
  - the FSM state enum `i2c_slv_state_t`;
  - constants `I2C_ACK = 1'b0` and `I2C_NACK = 1'b1`;
  - the sync depth constant.
- Sub-module `i2c_slave_in_filter` handles one line: synchronizer, optional majority filter and rise/fall detectors. It is instantiated twice, once for scl and once for sda.

## Test plan
- Master writes 48, 8'h10, 8'hA5, 8'h5A, then STOP →
  - ACK on all four bytes;
  - `wr_stb` ×2 with (10,A5) and (11,5A);
  - `host_addr = 8'h11` gives `host_rdata = 8'h5A`.
- Master writes 48, 8'h10, then repeated START, 49, then reads 2 bytes (ACK, then NACK) →
  - data returned is A5, 5A;
  - `busy` falls after the NACK.
- Address byte 50 →
  - sda is never driven low;
  - `busy` stays 0;
  - no `wr_stb`.
- Write with pointer 8'hFF, data 8'h11, 8'h22 → `mem[255] = 11` and `mem[0] = 22` (wrap).
- STOP after 4 bits of a data byte →
  - no `wr_stb`;
  - FSM returns to IDLE;
  - the next transaction is ACKed normally.
- `resetn` pulled low during an ACK window →
  - sda is 'z in the same cycle;
  - all outputs take their reset values.
